// File: rtl/mem_if_pkg.sv
// Shared encodings for the MFA/MOC memory handshake: access sizes, responder
// states and the alignment rule that decides whether a request is legal.
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Natural alignment: halfwords on even addresses, words on multiples of four.
  function automatic logic req_ok(input size_e sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide storage with a 4-byte big-endian read window and per-lane writes.
// Lane l covers address i_addr+l and data bits [31-8l -: 8].
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_we,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // NOTE: storage is deliberately not reset, so a bench preload survives RESET
  // and the array can map onto plain RAM macros.
  reg [7:0] memory [0:DEPTH-1];

  logic [ADDR_W-1:0] w_lane_addr [4];

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_lane_addr[l] = i_addr + ADDR_W'(l);
    end
  end

  // Lanes above the access size may wrap to low addresses; they are never used.
  assign o_rdata = {memory[w_lane_addr[0]], memory[w_lane_addr[1]],
                    memory[w_lane_addr[2]], memory[w_lane_addr[3]]};

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) begin
        memory[w_lane_addr[l]] <= i_wdata[31-8*l -: 8];
      end
    end
  end

endmodule

// File: rtl/ram_mfa_responder.sv
// Memory-side MFA/MOC responder: latches a request, waits WAIT_STATES cycles,
// performs a big-endian byte/half/word access and holds MOC until MFA drops.
module ram_mfa_responder
  import mem_if_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  output logic              ERR
);

  // A zero-width counter is illegal, so WAIT_STATES=0 still keeps one bit.
  localparam int               CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data_out;
  logic              r_moc;
  logic              r_err;

  logic        w_ok;
  logic        w_access;
  logic [3:0]  w_mask;
  logic [3:0]  w_we;
  logic [31:0] w_wdata_lanes;
  logic [31:0] w_rdata_lanes;
  logic [31:0] w_rdata;

  assign w_ok     = req_ok(r_size, r_addr[1:0]);
  assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_mask        = 4'b0000;
    w_wdata_lanes = 32'h0;
    w_rdata       = 32'h0;
    case (r_size)
      SZ_BYTE: begin
        w_mask        = 4'b0001;
        w_wdata_lanes = {r_wdata[7:0], 24'h0};
        w_rdata       = {24'h0, w_rdata_lanes[31:24]};
      end
      SZ_HALF: begin
        w_mask        = 4'b0011;
        w_wdata_lanes = {r_wdata[15:0], 16'h0};
        w_rdata       = {16'h0, w_rdata_lanes[31:16]};
      end
      SZ_WORD: begin
        w_mask        = 4'b1111;
        w_wdata_lanes = r_wdata;
        w_rdata       = w_rdata_lanes;
      end
      default: ;
    endcase
  end

  // RESET in the access cycle must discard the write, hence the gate here.
  assign w_we = (w_access && !r_rw && w_ok && !RESET) ? w_mask : 4'b0000;

  ram_byte_array #(
    .ADDR_W (ADDR_W)
  ) ram_byte_array (
    .i_clk   (CLK),
    .i_addr  (r_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata_lanes),
    .o_rdata (w_rdata_lanes)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rw       <= 1'b1;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_data_out <= 32'h0;
      r_moc      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MFA) begin
            r_rw    <= RW;
            r_size  <= size_e'(SIZE);
            r_addr  <= ADDR;
            r_wdata <= DATA_IN;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_moc   <= 1'b1;
            r_err   <= ~w_ok;
            r_state <= ST_DONE;
            if (!w_ok) begin
              r_data_out <= 32'h0;
            end else if (r_rw) begin
              r_data_out <= w_rdata;
            end
          end
        end
        ST_DONE: begin
          if (!MFA) begin
            r_moc   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DATA_OUT = r_data_out;
  assign MOC      = r_moc;
  assign ERR      = r_err;

endmodule

// File: tb/tb_ram_mfa_responder.sv
// Drives two responders (WAIT_STATES=0 and 2) with the same request stream;
// per-DUT scoreboards compare DATA_OUT/ERR whenever MOC rises.
module tb_ram_mfa_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout0, dout2;
  logic        moc0, moc2, err0, err2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;
  logic prev0 = 1'b0;
  logic prev2 = 1'b0;

  always #5 clk = ~clk;

  ram_mfa_responder #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
    .CLK(clk), .RESET(rst), .MFA(mfa), .RW(rw), .SIZE(size), .ADDR(addr),
    .DATA_IN(din), .DATA_OUT(dout0), .MOC(moc0), .ERR(err0)
  );

  ram_mfa_responder #(.WAIT_STATES(2), .ADDR_W(8)) dut2 (
    .CLK(clk), .RESET(rst), .MFA(mfa), .RW(rw), .SIZE(size), .ADDR(addr),
    .DATA_IN(din), .DATA_OUT(dout2), .MOC(moc2), .ERR(err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (moc0 && !prev0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ws0_unexpected_moc: got MOC rise expected none");
      end else begin
        e0 = q0.pop_front();
        check("ws0_err", {31'h0, err0}, {31'h0, e0.err});
        if (e0.chk_data) check("ws0_data", dout0, e0.data);
      end
    end
    prev0 = moc0;
  end

  always @(negedge clk) begin
    if (moc2 && !prev2) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ws2_unexpected_moc: got MOC rise expected none");
      end else begin
        e2 = q2.pop_front();
        check("ws2_err", {31'h0, err2}, {31'h0, e2.err});
        if (e2.chk_data) check("ws2_data", dout2, e2.data);
      end
    end
    prev2 = moc2;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    dut0.ram_byte_array.memory[a] = v;
    dut2.ram_byte_array.memory[a] = v;
  endtask

  task automatic check_mem(input logic [7:0] a, input logic [7:0] v);
    check($sformatf("ws0_mem_%h", a), {24'h0, dut0.ram_byte_array.memory[a]}, {24'h0, v});
    check($sformatf("ws2_mem_%h", a), {24'h0, dut2.ram_byte_array.memory[a]}, {24'h0, v});
  endtask

  task automatic expect_resp(input logic is_read, input logic [31:0] d, input logic e);
    exp_t x;
    x.data     = d;
    x.err      = e;
    x.chk_data = is_read || e;
    q0.push_back(x);
    q2.push_back(x);
  endtask

  // Full handshake; latency counts edges from the capture edge (=1) to MOC high.
  task automatic do_req(input logic r, input logic [1:0] sz, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e, input int hold);
    int lat0, lat2;
    expect_resp(r, exp_d, exp_e);
    @(negedge clk);
    mfa = 1'b1; rw = r; size = sz; addr = a; din = wd;
    lat0 = -1;
    lat2 = -1;
    for (int k = 1; k <= 10 && (lat0 < 0 || lat2 < 0); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        rw = ~r; addr = ~a; din = ~wd;
      end
      if (moc0 && lat0 < 0) lat0 = k;
      if (moc2 && lat2 < 0) lat2 = k;
    end
    check("ws0_latency", lat0, 2);
    check("ws2_latency", lat2, 4);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("ws0_moc_hold", {31'h0, moc0}, 32'h1);
      check("ws2_moc_hold", {31'h0, moc2}, 32'h1);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk); #1;
    check("ws0_moc_fall", {31'h0, moc0}, 32'h0);
    check("ws2_moc_fall", {31'h0, moc2}, 32'h0);
    check("ws0_err_fall", {31'h0, err0}, 32'h0);
    check("ws2_err_fall", {31'h0, err2}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mfa = 1'b0; rw = 1'b1; size = 2'b00; addr = 8'h00; din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("ws0_rst_moc", {31'h0, moc0}, 32'h0);
    check("ws2_rst_moc", {31'h0, moc2}, 32'h0);
    check("ws0_rst_err", {31'h0, err0}, 32'h0);
    check("ws2_rst_err", {31'h0, err2}, 32'h0);
    check("ws0_rst_dout", dout0, 32'h0);
    check("ws2_rst_dout", dout2, 32'h0);

    poke(8'h00, 8'hDE); poke(8'h01, 8'hAD); poke(8'h02, 8'hBE); poke(8'h03, 8'hEF);
    poke(8'h04, 8'h11); poke(8'h05, 8'h22);
    poke(8'h10, 8'h3C); poke(8'h12, 8'h77);
    poke(8'h20, 8'hC0); poke(8'h21, 8'hFF); poke(8'h22, 8'hEE); poke(8'h23, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Word read, byte write, halfword read across the new byte.
    do_req(1'b1, 2'b10, 8'h00, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b0, 2'b00, 8'h11, 32'h000000A5, 32'h0, 1'b0, 0);
    do_req(1'b1, 2'b01, 8'h10, 32'h0, 32'h00003CA5, 1'b0, 0);
    check_mem(8'h12, 8'h77);

    // Top-of-array word, read back bytewise.
    do_req(1'b0, 2'b10, 8'hFC, 32'h12345678, 32'h0, 1'b0, 0);
    do_req(1'b1, 2'b00, 8'hFC, 32'h0, 32'h00000012, 1'b0, 0);
    do_req(1'b1, 2'b00, 8'hFD, 32'h0, 32'h00000034, 1'b0, 0);
    do_req(1'b1, 2'b00, 8'hFE, 32'h0, 32'h00000056, 1'b0, 0);
    do_req(1'b1, 2'b00, 8'hFF, 32'h0, 32'h00000078, 1'b0, 0);

    // Misaligned and reserved requests.
    do_req(1'b1, 2'b01, 8'h05, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b0, 2'b10, 8'h02, 32'hCAFEF00D, 32'h0, 1'b1, 0);
    do_req(1'b1, 2'b11, 8'h00, 32'h0, 32'h0, 1'b1, 0);
    check_mem(8'h02, 8'hBE); check_mem(8'h03, 8'hEF);
    check_mem(8'h04, 8'h11); check_mem(8'h05, 8'h22);

    // RESET during BUSY discards the write.
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = 2'b10; addr = 8'h20; din = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("ws0_rst_busy_moc", {31'h0, moc0}, 32'h0);
      check("ws2_rst_busy_moc", {31'h0, moc2}, 32'h0);
    end
    check("ws2_rst_busy_dout", dout2, 32'h0);
    check_mem(8'h20, 8'hC0); check_mem(8'h23, 8'h00);
    do_req(1'b1, 2'b10, 8'h20, 32'h0, 32'hC0FFEE00, 1'b0, 0);

    // MFA held high: MOC stays and no second access happens.
    do_req(1'b1, 2'b00, 8'h00, 32'h0, 32'h000000DE, 1'b0, 4);

    // MFA dropped during BUSY.
    expect_resp(1'b1, 32'h000000AD, 1'b0);
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; size = 2'b00; addr = 8'h01; din = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk); #1;
    check("ws0_early_moc_n1", {31'h0, moc0}, 32'h1);
    check("ws2_early_moc_n1", {31'h0, moc2}, 32'h0);
    @(posedge clk); #1;
    check("ws0_early_moc_n2", {31'h0, moc0}, 32'h0);
    check("ws2_early_moc_n2", {31'h0, moc2}, 32'h0);
    @(posedge clk); #1;
    check("ws2_early_moc_n3", {31'h0, moc2}, 32'h1);
    @(posedge clk); #1;
    check("ws2_early_moc_n4", {31'h0, moc2}, 32'h0);

    // Back-to-back requests separated by a single MFA-low cycle.
    do_req(1'b0, 2'b01, 8'h40, 32'h0000BEAD, 32'h0, 1'b0, 0);
    do_req(1'b1, 2'b01, 8'h40, 32'h0, 32'h0000BEAD, 1'b0, 0);
    do_req(1'b1, 2'b00, 8'h41, 32'h0, 32'h000000AD, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("ws0_queue_empty", q0.size(), 0);
    check("ws2_queue_empty", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
